// File: rtl/nios_simple_gpio_bidir.sv
// nios_simple_gpio_bidir: Avalon-MM bidirectional GPIO with set/clear, direction and registered reads.
// Optional edge capture, mask and irq are included when GPIO_BIDIR_EDGECAP_EN is defined.
module nios_simple_gpio_bidir #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter int EDGE_TYPE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic        irq
);
  logic [WIDTH-1:0] data_out, dir, meta, sync, wdata;
  logic [31:0] rd_next;
  logic wr, unused_wdata;
  assign wr = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir <= '0;
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= bidir_port;
      sync <= meta;
      if (wr)
        data_out <= address == 3'd0 ? wdata :
                    address == 3'd4 ? data_out | wdata :
                    address == 3'd5 ? data_out & ~wdata : data_out;
      if (wr && address == 3'd1) dir <= wdata;
    end
`ifdef GPIO_BIDIR_EDGECAP_EN
  logic [WIDTH-1:0] mask, edgecap, prev, edges, clr;
  always_comb begin
    edges = EDGE_TYPE == 0 ? sync & ~prev : EDGE_TYPE == 1 ? ~sync & prev : sync ^ prev;
    clr = (wr && address == 3'd3) ? wdata : '0;
  end
  // a fresh edge overrides a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mask <= '0;
      edgecap <= '0;
      prev <= '0;
    end else begin
      prev <= sync;
      if (wr && address == 3'd2) mask <= wdata;
      edgecap <= (edgecap & ~clr) | edges;
    end
  assign irq = |(edgecap & mask);
  always_comb
    rd_next = address == 3'd0 ? 32'(sync) :
              address == 3'd1 ? 32'(dir) :
              address == 3'd2 ? 32'(mask) :
              address == 3'd3 ? 32'(edgecap) : 32'd0;
`else
  assign irq = 1'b0;
  always_comb
    rd_next = address == 3'd0 ? 32'(sync) :
              address == 3'd1 ? 32'(dir) : 32'd0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= rd_next;
endmodule
